// File: rtl/song_note_sequencer.sv
// Song ROM walker feeding composite_note_player: fetches {note, duration} words and strobes them out on player request.
// Optional build macro SONG_LOOP_EN: restart the song at word 0 instead of stopping in DONE.
module song_note_sequencer #(
   parameter int ADDR_W  = 7,
   parameter int SONG_W  = 2,
   parameter int ROM_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     play,
   input  logic [SONG_W-1:0]        song_sel,
   input  logic                     available,
   input  logic [11:0]              rom_data,
   output logic [SONG_W+ADDR_W-1:0] rom_addr,
   output logic [11:0]              next_song_note,
   output logic                     load_new_note,
   output logic                     song_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT_ROM, S_CHECK, S_WAIT_PLAYER,
      S_HOLDOFF, S_WAIT_DROP, S_NEXT, S_DONE
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(ROM_LAT);

   state_t                     r_state;
   state_t                     w_next;
   logic [SONG_W-1:0]          r_song_sel_q;
   logic [ADDR_W-1:0]          r_word_addr;
   logic [1:0]                 r_lat_cnt;
   logic [1:0]                 r_drop_cnt;
   logic [11:0]                r_hold;
   logic [SONG_W+ADDR_W-1:0]   r_rom_addr;
   logic [11:0]                r_note;
   logic                       r_load;
   logic                       r_song_done;
   logic                       w_fire;
   logic                       w_end_marker;
   logic                       w_wrapped;

   assign w_fire       = available && play;
   assign w_end_marker = (r_hold == 12'h000);
   assign w_wrapped    = (r_word_addr == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:        if (play) w_next = S_FETCH;
         S_FETCH:       w_next = S_WAIT_ROM;
         S_WAIT_ROM:    if (r_lat_cnt == 2'd1) w_next = S_CHECK;
`ifdef SONG_LOOP_EN
         S_CHECK:       w_next = w_end_marker ? S_FETCH : S_WAIT_PLAYER;
`else
         S_CHECK:       w_next = w_end_marker ? S_DONE : S_WAIT_PLAYER;
`endif
         S_WAIT_PLAYER: if (w_fire) w_next = S_HOLDOFF;
         S_HOLDOFF:     w_next = S_WAIT_DROP;
         S_WAIT_DROP:   if (!available || (r_drop_cnt == 2'd3)) w_next = S_NEXT;
`ifdef SONG_LOOP_EN
         S_NEXT:        w_next = S_FETCH;
         S_DONE:        w_next = S_IDLE;
`else
         S_NEXT:        w_next = w_wrapped ? S_DONE : S_FETCH;
         S_DONE:        if (!play) w_next = S_IDLE;
`endif
         default:       w_next = S_IDLE;
      endcase
   end

   // rom_addr is updated on entry to FETCH so the ROM sees it during FETCH and it stays put through WAIT_ROM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_song_sel_q <= '0;
         r_word_addr  <= '0;
         r_lat_cnt    <= '0;
         r_drop_cnt   <= '0;
         r_hold       <= '0;
         r_rom_addr   <= '0;
         r_note       <= '0;
         r_load       <= 1'b0;
         r_song_done  <= 1'b0;
      end else begin
         r_load <= 1'b0;
`ifdef SONG_LOOP_EN
         r_song_done <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (play) begin
                  r_song_sel_q <= song_sel;
                  r_word_addr  <= '0;
                  r_song_done  <= 1'b0;
                  r_rom_addr   <= {song_sel, {ADDR_W{1'b0}}};
               end
            end
            S_FETCH: begin
               r_lat_cnt <= LAT_INIT;
            end
            S_WAIT_ROM: begin
               r_lat_cnt <= r_lat_cnt - 2'd1;
               if (r_lat_cnt == 2'd1) r_hold <= rom_data;
            end
            S_CHECK: begin
               if (w_end_marker) begin
                  r_song_done <= 1'b1;
`ifdef SONG_LOOP_EN
                  r_word_addr <= '0;
                  r_rom_addr  <= {r_song_sel_q, {ADDR_W{1'b0}}};
`endif
               end
            end
            S_WAIT_PLAYER: begin
               if (w_fire) begin
                  r_note      <= r_hold;
                  r_load      <= 1'b1;
                  r_word_addr <= r_word_addr + 1'b1;
               end
            end
            S_HOLDOFF: begin
               r_drop_cnt <= '0;
            end
            S_WAIT_DROP: begin
               r_drop_cnt <= r_drop_cnt + 2'd1;
            end
            S_NEXT: begin
               r_rom_addr <= {r_song_sel_q, r_word_addr};
               if (w_wrapped) r_song_done <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign rom_addr       = r_rom_addr;
   assign next_song_note = r_note;
   assign load_new_note  = r_load;
   assign song_done      = r_song_done;

endmodule

// File: doc/song_note_sequencer.md
Name: song_note_sequencer

Overview:
Upstream feeder for composite_note_player in SONG_PLAYER mode. Walks a synchronous song ROM and presents each {note, duration} word on next_song_note. Pulses load_new_note whenever the player reports available. Handles play/pause, song selection and end-of-song detection.

Parameters:
ADDR_W, 7, per-song word address width; each song occupies 2^ADDR_W ROM words.
SONG_W, 2, song-select width; ROM address = {song_sel_q, word_addr}.
ROM_LAT, 1, song ROM read latency in clocks; legal values 1..3.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
play  in  1  level; 1 = advance through song, 0 = pause.
song_sel  in  SONG_W  song index; sampled only in IDLE.
available  in  1  from composite_note_player; 1 = ready for next note.
rom_data  in  12  ROM read data {note[11:6], duration[5:0]}, valid ROM_LAT clocks after rom_addr.
rom_addr  out  SONG_W+ADDR_W  ROM address.
next_song_note  out  12  registered note word to player.
load_new_note  out  1  single-cycle strobe; next_song_note valid in the same cycle.
song_done  out  1  level; end of song reached.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rom_addr=0, next_song_note=0, load_new_note=0, song_done=0.
  - Internal word address and latency counter cleared.
- States:
  - IDLE: if play=1, latch song_sel into song_sel_q, word_addr=0, clear song_done, go to FETCH.
  - FETCH: drive rom_addr={song_sel_q, word_addr}, load latency counter with ROM_LAT, go to WAIT_ROM.
  - WAIT_ROM: decrement counter; when it reaches 0, capture rom_data into a holding register, go to CHECK.
  - CHECK:
    - Word == 12'h000 (end marker): go to DONE.
    - Otherwise go to WAIT_PLAYER. A word with note=0 and duration!=0 is a rest and is sent normally.
  - WAIT_PLAYER: when available=1 and play=1:
    - next_song_note <= holding word; load_new_note=1 for exactly one cycle.
    - word_addr increments; go to HOLDOFF.
  - HOLDOFF: one cycle with available ignored, so the player can drop it; then go to WAIT_DROP.
  - WAIT_DROP:
    - available=0: go to NEXT.
    - available still 1 after 4 cycles: go to NEXT anyway. This covers a zero-duration word the player completes instantly.
  - NEXT:
    - word_addr wrapped to 0 (all 2^ADDR_W words consumed): go to DONE.
    - Otherwise go to FETCH.
  - DONE: song_done=1. Stays until play=0, then returns to IDLE; song_done stays 1 until the next IDLE->FETCH transition.
- Pause:
  - play=0 blocks only the WAIT_PLAYER->load transition. ROM prefetch still completes.
  - Resuming play issues the held note with no re-fetch.
- Latency: from the cycle available rises in WAIT_PLAYER to the load_new_note strobe is 1 clock.
- Address rules:
  - word_addr arithmetic is modulo 2^ADDR_W.
  - rom_addr is held stable from FETCH through the end of WAIT_ROM.
- Simultaneous events: play falling in the same cycle available rises: no load is issued.
- song_sel changes outside IDLE have no effect.
- Reset mid-note: outputs clear immediately. No load_new_note is issued until a fresh FETCH after play=1.

Optional Feature:
SONG_LOOP_EN:
- When defined: end marker or address wrap does not enter DONE. word_addr goes to 0 and the sequencer continues at FETCH; song_done pulses high for one cycle on each wrap.
- When undefined: behaviour is as specified above (DONE, level song_done).

Test Plan:
1. ROM song0 = {12'hE08, 12'h1C4, 12'h000}, play=1, available tied high after 2-cycle drops:
   - exactly two load_new_note pulses, with next_song_note=12'hE08 then 12'h1C4.
   - then song_done=1 and no further strobes.
2. ROM_LAT=3, song_sel=2'b01:
   - rom_addr=9'h080 after leaving IDLE.
   - rom_data captured on the 3rd clock after FETCH; first load carries ROM[0x080].
3. Pause: play=0 in WAIT_PLAYER with available=1 for 20 cycles:
   - no load_new_note while paused.
   - play=1 gives a strobe within 1 clock, carrying the held word; rom_addr unchanged while paused.
4. Rest and zero-duration words: rest 12'h005 is sent as a normal load. Word 12'h040 with available never dropping: sequencer advances after the 4-cycle WAIT_DROP timeout, no hang.
5. Reset asserted (reset=0) mid-WAIT_DROP:
   - all outputs 0 in the same cycle.
   - after release with play=1, the first load comes from word 0 of the selected song.
6. SONG_LOOP_EN defined, song0 = {12'hE08, 12'h000}:
   - load 12'h E08 repeats every pass; song_done pulses one cycle per pass and never holds.
